dcache_port_arbiter: RTL and testbench

Shares the single DCache4KB request/response port between two requesters: port 0 is the LoadStoreQueue memory side and port 1 is a secondary client (fetch-miss or prefetch path). The arbiter grants requests round-robin and registers them toward the cache. It tags each request's ldstID with the requester index, and routes cache responses back by tag. It also tracks outstanding requests per port, so neither requester can exceed its credit budget.

---
 rtl/dcache_port_arbiter_pkg.sv | 18 +
 rtl/dcache_port_arbiter_out_credit_ctr.sv | 41 ++++
 rtl/dcache_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared constants for the DCache port arbiter: default widths, requester
// port indices and the layout of the cache-side ldstID (port tag in the MSB).
package dcache_port_arbiter_pkg;

   localparam int unsigned DEF_ID_W    = 4;
   localparam int unsigned DEF_ADDR_W  = 32;
   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_MAX_OUT = 4;

   localparam logic PORT_LSQ = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   // Bit position of the requester tag inside the cache-side ldstID.
   function automatic int unsigned tag_bit(input int unsigned id_w);
      return id_w - 1;
   endfunction

endpackage

// File: rtl/dcache_port_arbiter_out_credit_ctr.sv
// Per-port outstanding-request counter.
// Ports: clk_i, rst_i (sync, active high); inc_i (grant), dec_i (response);
// avail_c_o: room for one more grant this cycle, counting a same-cycle response;
// underflow_c_o: response arrived with nothing outstanding; zero_o: count is 0.
module out_credit_ctr #(
   parameter int unsigned MAX_OUT = 4,
   localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic avail_c_o,
   output logic underflow_c_o,
   output logic zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dec_ok;

   // A response at zero count is flagged and ignored so the counter never wraps.
   always_comb begin
      cnt_d         = cnt_q;
      dec_ok        = dec_i && (cnt_q != '0);
      underflow_c_o = dec_i && (cnt_q == '0);
      avail_c_o     = (cnt_q < CNT_W'(MAX_OUT)) || dec_ok;
      case ({inc_i, dec_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dcache_port_arbiter.sv
// Two-requester round-robin arbiter in front of the single DCache port.
// Port 0 = LSQ, port 1 = aux client. Requests are registered toward the cache
// with the port index in the ldstID MSB; responses are routed back by that bit.
// Ports: p{0,1}_* request/response per requester, mem_* cache request and
// response, idle (nothing outstanding, no request), err (sticky spurious response).
module dcache_port_arbiter
   import dcache_port_arbiter_pkg::*;
#(
   parameter int unsigned ID_W    = DEF_ID_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned MAX_OUT = DEF_MAX_OUT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p0_valid_i,
   input  logic              p0_rw_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_wdata_i,
   input  logic [ID_W-2:0]   p0_id_i,
   output logic              p0_ready_o,
   output logic              p0_rsp_valid_o,
   output logic [ID_W-2:0]   p0_rsp_id_o,
   output logic [DATA_W-1:0] p0_rsp_data_o,
   input  logic              p1_valid_i,
   input  logic              p1_rw_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_wdata_i,
   input  logic [ID_W-2:0]   p1_id_i,
   output logic              p1_ready_o,
   output logic              p1_rsp_valid_o,
   output logic [ID_W-2:0]   p1_rsp_id_o,
   output logic [DATA_W-1:0] p1_rsp_data_o,
   output logic              mem_valid_o,
   output logic              mem_rw_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [ID_W-1:0]   mem_id_o,
   input  logic              mem_stall_i,
   input  logic              mem_rsp_valid_i,
   input  logic [ID_W-1:0]   mem_rsp_id_i,
   input  logic [DATA_W-1:0] mem_rsp_data_i,
   output logic              idle_o,
   output logic              err_o
);

   localparam int unsigned TAG = tag_bit(ID_W);

   logic              mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [ID_W-1:0]   mem_id_q, mem_id_d;
   logic              last_q, last_d, err_q, err_d;
   logic              rv0_q, rv0_d, rv1_q, rv1_d;
   logic [ID_W-2:0]   rid0_q, rid0_d, rid1_q, rid1_d;
   logic [DATA_W-1:0] rdat0_q, rdat0_d, rdat1_q, rdat1_d;

   logic slot_free, dec0, dec1, el0, el1, g0, g1;
   logic av0, av1, uf0, uf1, z0, z1;

   out_credit_ctr #(.MAX_OUT(MAX_OUT)) u_cred0 (
      .clk_i(clk_i), .rst_i(rst_i), .inc_i(g0), .dec_i(dec0),
      .avail_c_o(av0), .underflow_c_o(uf0), .zero_o(z0)
   );

   out_credit_ctr #(.MAX_OUT(MAX_OUT)) u_cred1 (
      .clk_i(clk_i), .rst_i(rst_i), .inc_i(g1), .dec_i(dec1),
      .avail_c_o(av1), .underflow_c_o(uf1), .zero_o(z1)
   );

   // Round-robin grant: on a tie the port that did not win last time goes.
   always_comb begin
      slot_free = !mem_valid_q || !mem_stall_i;
      dec0      = mem_rsp_valid_i && (mem_rsp_id_i[TAG] == PORT_LSQ);
      dec1      = mem_rsp_valid_i && (mem_rsp_id_i[TAG] == PORT_AUX);
      el0       = p0_valid_i && av0;
      el1       = p1_valid_i && av1;
      g0        = slot_free && el0 && (!el1 || (last_q == PORT_AUX));
      g1        = slot_free && el1 && (!el0 || (last_q == PORT_LSQ));
   end

   // Request register, response routing and sticky error next-state.
   always_comb begin
      mem_valid_d = mem_valid_q;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_id_d    = mem_id_q;
      last_d      = last_q;
      rid0_d      = rid0_q;
      rdat0_d     = rdat0_q;
      rid1_d      = rid1_q;
      rdat1_d     = rdat1_q;
      rv0_d       = dec0;
      rv1_d       = dec1;
      err_d       = err_q || uf0 || uf1;
      if (g0) begin
         mem_valid_d = 1'b1;
         mem_rw_d    = p0_rw_i;
         mem_addr_d  = p0_addr_i;
         mem_wdata_d = p0_wdata_i;
         mem_id_d    = {PORT_LSQ, p0_id_i};
         last_d      = PORT_LSQ;
      end else if (g1) begin
         mem_valid_d = 1'b1;
         mem_rw_d    = p1_rw_i;
         mem_addr_d  = p1_addr_i;
         mem_wdata_d = p1_wdata_i;
         mem_id_d    = {PORT_AUX, p1_id_i};
         last_d      = PORT_AUX;
      end else if (!mem_stall_i) begin
         mem_valid_d = 1'b0;
      end
      if (dec0) begin
         rid0_d  = mem_rsp_id_i[ID_W-2:0];
         rdat0_d = mem_rsp_data_i;
      end
      if (dec1) begin
         rid1_d  = mem_rsp_id_i[ID_W-2:0];
         rdat1_d = mem_rsp_data_i;
      end
   end

   // last_q resets to port 1 so port 0 wins the first tie.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_valid_q <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_id_q    <= '0;
         last_q      <= PORT_AUX;
         err_q       <= 1'b0;
         rv0_q       <= 1'b0;
         rv1_q       <= 1'b0;
         rid0_q      <= '0;
         rid1_q      <= '0;
         rdat0_q     <= '0;
         rdat1_q     <= '0;
      end else begin
         mem_valid_q <= mem_valid_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_id_q    <= mem_id_d;
         last_q      <= last_d;
         err_q       <= err_d;
         rv0_q       <= rv0_d;
         rv1_q       <= rv1_d;
         rid0_q      <= rid0_d;
         rid1_q      <= rid1_d;
         rdat0_q     <= rdat0_d;
         rdat1_q     <= rdat1_d;
      end
   end

   assign p0_ready_o     = g0;
   assign p1_ready_o     = g1;
   assign mem_valid_o    = mem_valid_q;
   assign mem_rw_o       = mem_rw_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_wdata_o    = mem_wdata_q;
   assign mem_id_o       = mem_id_q;
   assign p0_rsp_valid_o = rv0_q;
   assign p0_rsp_id_o    = rid0_q;
   assign p0_rsp_data_o  = rdat0_q;
   assign p1_rsp_valid_o = rv1_q;
   assign p1_rsp_id_o    = rid1_q;
   assign p1_rsp_data_o  = rdat1_q;
   assign err_o          = err_q;
   assign idle_o         = z0 && z1 && !mem_valid_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_dcache_port_arbiter;

   localparam int MAXO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, p0_valid, p0_rw, p1_valid, p1_rw, mem_stall, mem_rsp_valid;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, mem_rsp_data;
   logic [2:0]  p0_id, p1_id;
   logic [3:0]  mem_rsp_id;
   logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid;
   logic [2:0]  p0_rsp_id, p1_rsp_id;
   logic [31:0] p0_rsp_data, p1_rsp_data, mem_addr, mem_wdata;
   logic        mem_valid, mem_rw, idle, err;
   logic [3:0]  mem_id;

   dcache_port_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .p0_valid_i(p0_valid), .p0_rw_i(p0_rw), .p0_addr_i(p0_addr),
      .p0_wdata_i(p0_wdata), .p0_id_i(p0_id), .p0_ready_o(p0_ready),
      .p0_rsp_valid_o(p0_rsp_valid), .p0_rsp_id_o(p0_rsp_id), .p0_rsp_data_o(p0_rsp_data),
      .p1_valid_i(p1_valid), .p1_rw_i(p1_rw), .p1_addr_i(p1_addr),
      .p1_wdata_i(p1_wdata), .p1_id_i(p1_id), .p1_ready_o(p1_ready),
      .p1_rsp_valid_o(p1_rsp_valid), .p1_rsp_id_o(p1_rsp_id), .p1_rsp_data_o(p1_rsp_data),
      .mem_valid_o(mem_valid), .mem_rw_o(mem_rw), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_id_o(mem_id), .mem_stall_i(mem_stall),
      .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_id_i(mem_rsp_id),
      .mem_rsp_data_i(mem_rsp_data), .idle_o(idle), .err_o(err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: outstanding counts, last winner, expected registered outputs.
   int          m_cnt[2];
   bit          m_last, m_mvalid, m_mrw, m_err;
   logic [31:0] m_maddr, m_mwdata;
   logic [3:0]  m_mid;
   bit          m_rv[2];
   logic [2:0]  m_rid[2];
   logic [31:0] m_rdata[2];
   logic [2:0]  outq0[$], outq1[$];

   int          n_cnt[2], n_g;
   bit          n_last, n_mvalid, n_mrw, n_err;
   logic [31:0] n_maddr, n_mwdata;
   logic [3:0]  n_mid;
   bit          n_rv[2];
   logic [2:0]  n_rid[2];
   logic [31:0] n_rdata[2];
   bit          e_rdy0, e_rdy1;

   task automatic clear_inputs();
      rst = 1'b0; p0_valid = 1'b0; p0_rw = 1'b0; p0_addr = '0; p0_wdata = '0; p0_id = '0;
      p1_valid = 1'b0; p1_rw = 1'b0; p1_addr = '0; p1_wdata = '0; p1_id = '0;
      mem_stall = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_id = '0; mem_rsp_data = '0;
   endtask

   // Let inputs settle, then predict this cycle's grant and next register state.
   task automatic eval();
      bit sf;
      bit dec[2];
      int eff[2];
      bit el[2];
      #1;
      sf = !m_mvalid || !mem_stall;
      for (int p = 0; p < 2; p++) begin
         dec[p] = mem_rsp_valid && (int'(mem_rsp_id[3]) == p);
         eff[p] = (dec[p] && m_cnt[p] > 0) ? m_cnt[p] - 1 : m_cnt[p];
      end
      el[0] = p0_valid && (eff[0] < MAXO);
      el[1] = p1_valid && (eff[1] < MAXO);
      n_g = -1;
      if (sf) begin
         if (el[0] && el[1]) n_g = m_last ? 0 : 1;
         else if (el[0])     n_g = 0;
         else if (el[1])     n_g = 1;
      end
      e_rdy0 = (n_g == 0);
      e_rdy1 = (n_g == 1);
      n_err = m_err;
      for (int p = 0; p < 2; p++) begin
         n_cnt[p]   = eff[p] + ((n_g == p) ? 1 : 0);
         if (dec[p] && m_cnt[p] == 0) n_err = 1'b1;
         n_rv[p]    = dec[p];
         n_rid[p]   = dec[p] ? mem_rsp_id[2:0] : m_rid[p];
         n_rdata[p] = dec[p] ? mem_rsp_data : m_rdata[p];
      end
      n_mvalid = m_mvalid; n_mrw = m_mrw; n_maddr = m_maddr; n_mwdata = m_mwdata;
      n_mid = m_mid; n_last = m_last;
      if (n_g == 0) begin
         n_mvalid = 1'b1; n_mrw = p0_rw; n_maddr = p0_addr; n_mwdata = p0_wdata;
         n_mid = {1'b0, p0_id}; n_last = 1'b0;
      end else if (n_g == 1) begin
         n_mvalid = 1'b1; n_mrw = p1_rw; n_maddr = p1_addr; n_mwdata = p1_wdata;
         n_mid = {1'b1, p1_id}; n_last = 1'b1;
      end else if (!mem_stall) begin
         n_mvalid = 1'b0;
      end
      if (rst) begin
         n_g = -1; n_err = 1'b0; n_last = 1'b1; n_mvalid = 1'b0; n_mrw = 1'b0;
         n_maddr = '0; n_mwdata = '0; n_mid = '0;
         for (int p = 0; p < 2; p++) begin
            n_cnt[p] = 0; n_rv[p] = 1'b0; n_rid[p] = '0; n_rdata[p] = '0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         outq0.delete(); outq1.delete();
      end else if (n_g == 0) outq0.push_back(p0_id);
      else if (n_g == 1) outq1.push_back(p1_id);
      m_cnt = n_cnt; m_last = n_last; m_mvalid = n_mvalid; m_mrw = n_mrw;
      m_maddr = n_maddr; m_mwdata = n_mwdata; m_mid = n_mid; m_err = n_err;
      m_rv = n_rv; m_rid = n_rid; m_rdata = n_rdata;
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      eval(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({mem_valid, mem_rw, mem_addr, mem_wdata, mem_id, p0_rsp_valid, p0_rsp_id, p0_rsp_data,
           p1_rsp_valid, p1_rsp_id, p1_rsp_data, err} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: some output nonzero (mem_valid=%b err=%b)", mem_valid, err);
      end
      n_tests++;
      if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b exp 1", idle); end
   endtask

   task automatic test_write();
      do_reset();
      p0_valid = 1'b1; p0_rw = 1'b1; p0_addr = 32'd40; p0_wdata = 32'd9000; p0_id = 3'd1;
      eval();
      n_tests++;
      if ({p0_ready, p1_ready} !== 2'b10) begin
         n_fail++; $display("FAIL write_ready: got %b exp 10", {p0_ready, p1_ready});
      end
      tick(); clear_inputs();
      n_tests++;
      if ({mem_valid, mem_rw, mem_addr, mem_wdata, mem_id} !== {1'b1, 1'b1, 32'd40, 32'd9000, 4'b0001}) begin
         n_fail++;
         $display("FAIL write_req: got v=%b rw=%b a=%0d d=%0d id=%b exp 1 1 40 9000 0001",
                  mem_valid, mem_rw, mem_addr, mem_wdata, mem_id);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      p0_valid = 1'b1; p0_addr = 32'd40; p1_valid = 1'b1; p1_addr = 32'd44;
      for (int k = 0; k < 4; k++) begin
         eval();
         n_tests++;
         if ({p0_ready, p1_ready} !== ((k % 2) != 0 ? 2'b01 : 2'b10)) begin
            n_fail++; $display("FAIL rr_ready[%0d]: got %b", k, {p0_ready, p1_ready});
         end
         tick();
         n_tests++;
         if ({mem_id[3], mem_addr} !== {1'((k % 2) != 0), ((k % 2) != 0) ? 32'd44 : 32'd40}) begin
            n_fail++; $display("FAIL rr_mem[%0d]: got tag=%b addr=%0d", k, mem_id[3], mem_addr);
         end
      end
      clear_inputs();
   endtask

   task automatic test_stall();
      do_reset();
      p0_valid = 1'b1; p0_rw = 1'b1; p0_addr = 32'd100; p0_wdata = 32'd7; p0_id = 3'd2;
      eval(); tick();
      mem_stall = 1'b1; p0_addr = 32'd200; p1_valid = 1'b1; p1_addr = 32'd300; p1_id = 3'd5;
      for (int k = 0; k < 3; k++) begin
         eval();
         n_tests++;
         if ({p0_ready, p1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL stall_ready[%0d]: got %b exp 00", k, {p0_ready, p1_ready});
         end
         tick();
         n_tests++;
         if ({mem_valid, mem_rw, mem_addr, mem_wdata, mem_id} !== {1'b1, 1'b1, 32'd100, 32'd7, 4'b0010}) begin
            n_fail++; $display("FAIL stall_hold[%0d]: got a=%0d id=%b v=%b", k, mem_addr, mem_id, mem_valid);
         end
      end
      mem_stall = 1'b0;
      eval();
      n_tests++;
      if ({p0_ready, p1_ready} !== 2'b01) begin
         n_fail++; $display("FAIL stall_release_ready: got %b exp 01", {p0_ready, p1_ready});
      end
      tick(); clear_inputs();
      n_tests++;
      if ({mem_valid, mem_addr, mem_id} !== {1'b1, 32'd300, 4'b1101}) begin
         n_fail++; $display("FAIL stall_release_req: got a=%0d id=%b exp 300 1101", mem_addr, mem_id);
      end
   endtask

   task automatic test_credit();
      do_reset();
      p1_valid = 1'b1; p1_addr = 32'd80;
      for (int k = 0; k < 4; k++) begin
         p1_id = 3'(k);
         eval();
         n_tests++;
         if (p1_ready !== 1'b1) begin n_fail++; $display("FAIL credit_fill[%0d]: got %b exp 1", k, p1_ready); end
         tick();
      end
      p0_valid = 1'b1; p0_addr = 32'd40; p1_id = 3'd4;
      eval();
      n_tests++;
      if ({p0_ready, p1_ready} !== 2'b10) begin
         n_fail++; $display("FAIL credit_full: got %b exp 10", {p0_ready, p1_ready});
      end
      tick();
      p0_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_id = 4'b1010; mem_rsp_data = 32'd9001;
      eval();
      n_tests++;
      if (p1_ready !== 1'b1) begin n_fail++; $display("FAIL credit_freed_grant: got %b exp 1", p1_ready); end
      tick(); clear_inputs();
      n_tests++;
      if ({p1_rsp_valid, p1_rsp_id, p1_rsp_data, p0_rsp_valid} !== {1'b1, 3'd2, 32'd9001, 1'b0}) begin
         n_fail++; $display("FAIL credit_rsp: got v=%b id=%0d d=%0d p0v=%b exp 1 2 9001 0",
                            p1_rsp_valid, p1_rsp_id, p1_rsp_data, p0_rsp_valid);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      mem_rsp_valid = 1'b1; mem_rsp_id = 4'b0011; mem_rsp_data = 32'd55;
      eval(); tick(); clear_inputs();
      n_tests++;
      if ({err, p0_rsp_valid, p0_rsp_id, p1_rsp_valid, idle} !== {1'b1, 1'b1, 3'd3, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL underflow: got err=%b v=%b id=%0d p1v=%b idle=%b exp 1 1 3 0 1",
                            err, p0_rsp_valid, p0_rsp_id, p1_rsp_valid, idle);
      end
      p0_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         eval();
         n_tests++;
         if (p0_ready !== 1'b1) begin n_fail++; $display("FAIL underflow_cnt0[%0d]: got %b exp 1", k, p0_ready); end
         tick();
      end
      clear_inputs(); eval(); tick();
      n_tests++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b exp 1", err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      p0_valid = 1'b1; eval(); tick();
      p0_valid = 1'b0; p1_valid = 1'b1; eval(); tick();
      clear_inputs(); rst = 1'b1; eval(); tick(); rst = 1'b0;
      n_tests++;
      if ({mem_valid, mem_id, err, p0_rsp_valid, p1_rsp_valid, idle} !== {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL reset_mid: got v=%b id=%b err=%b idle=%b", mem_valid, mem_id, err, idle);
      end
      p0_valid = 1'b1; p1_valid = 1'b1;
      eval();
      n_tests++;
      if ({p0_ready, p1_ready} !== 2'b10) begin
         n_fail++; $display("FAIL reset_mid_tie: got %b exp 10", {p0_ready, p1_ready});
      end
      tick(); clear_inputs();
      mem_rsp_valid = 1'b1; mem_rsp_id = 4'b1000;
      eval(); tick(); clear_inputs();
      n_tests++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL reset_mid_stale_rsp: err got %b exp 1", err); end
   endtask

   task automatic test_random();
      int p;
      do_reset();
      for (int cyc = 0; cyc < 500; cyc++) begin
         clear_inputs();
         p0_valid = ($urandom_range(0, 2) != 0); p0_rw = 1'($urandom);
         p0_addr = $urandom; p0_wdata = $urandom; p0_id = 3'($urandom);
         p1_valid = ($urandom_range(0, 2) != 0); p1_rw = 1'($urandom);
         p1_addr = $urandom; p1_wdata = $urandom; p1_id = 3'($urandom);
         mem_stall = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) != 0) begin
            p = int'($urandom_range(0, 1));
            if (p == 0 && outq0.size() == 0) p = 1;
            else if (p == 1 && outq1.size() == 0) p = 0;
            if (p == 0 && outq0.size() != 0) begin
               mem_rsp_valid = 1'b1; mem_rsp_id = {1'b0, outq0.pop_front()}; mem_rsp_data = $urandom;
            end else if (p == 1 && outq1.size() != 0) begin
               mem_rsp_valid = 1'b1; mem_rsp_id = {1'b1, outq1.pop_front()}; mem_rsp_data = $urandom;
            end
         end
         eval();
         n_tests++;
         if ({p0_ready, p1_ready} !== {e_rdy0, e_rdy1}) begin
            n_fail++; $display("FAIL rand_ready[%0d]: got %b exp %b", cyc, {p0_ready, p1_ready}, {e_rdy0, e_rdy1});
         end
         tick();
         n_tests++;
         if ({mem_valid, mem_rw, mem_addr, mem_wdata, mem_id} !== {m_mvalid, m_mrw, m_maddr, m_mwdata, m_mid}) begin
            n_fail++; $display("FAIL rand_mem[%0d]: got v=%b a=%h id=%b exp v=%b a=%h id=%b",
                               cyc, mem_valid, mem_addr, mem_id, m_mvalid, m_maddr, m_mid);
         end
         n_tests++;
         if ({p0_rsp_valid, p0_rsp_id, p0_rsp_data, p1_rsp_valid, p1_rsp_id, p1_rsp_data}
             !== {m_rv[0], m_rid[0], m_rdata[0], m_rv[1], m_rid[1], m_rdata[1]}) begin
            n_fail++; $display("FAIL rand_rsp[%0d]: got %b/%b exp %b/%b", cyc, p0_rsp_valid, p1_rsp_valid, m_rv[0], m_rv[1]);
         end
         n_tests++;
         if ({err, idle} !== {m_err, (m_cnt[0] == 0 && m_cnt[1] == 0 && !m_mvalid)}) begin
            n_fail++; $display("FAIL rand_status[%0d]: got err=%b idle=%b exp err=%b cnt=%0d/%0d",
                               cyc, err, idle, m_err, m_cnt[0], m_cnt[1]);
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_write();
      test_round_robin();
      test_stall();
      test_credit();
      test_underflow();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
